// File: rtl/sampler_pkg.sv
// rtl/sampler_pkg.sv - shared constants and types for the sampler note player
//
// Purpose: widths, note region length, player state encoding and the PCM
// sample type used by sampler_note_player and its event detector.
// Optional feature macro used by the player: SAMPLER_LOOP_EN.
package sampler_pkg;

  localparam int ADDR_W   = 20;     // sample memory word-address width
  localparam int DATA_W   = 16;     // PCM sample width
  localparam int NOTE_LEN = 32768;  // samples per note region
  localparam int OFFSET_W = 16;     // width of the in-note offset counter

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    FETCH     = 2'd2,
    DONE      = 2'd3
  } player_state_t;

  typedef logic [DATA_W-1:0] sample_t;

endpackage

// File: rtl/sampler_note_event_detect.sv
// rtl/sampler_note_event_detect.sv - note start / release strobe generation
//
// Purpose: compares the keymapper outputs against the latched note base and
// the player state, producing combinational note_event and note_release.
// Ports:
//   state        in   current player state
//   note_addr    in   start word address of the selected note (level)
//   invalid_note in   1 = no valid key pressed (level)
//   base         in   latched start address of the note being played
//   note_event   out  a (new) note should start
//   note_release out  the key was released while a note is active
module sampler_note_event_detect
  import sampler_pkg::*;
#(
  parameter int ADDR_W = sampler_pkg::ADDR_W
) (
  input  player_state_t     state,
  input  logic [ADDR_W-1:0] note_addr,
  input  logic              invalid_note,
  input  logic [ADDR_W-1:0] base,
  output logic              note_event,
  output logic              note_release
);

  // From IDLE any valid key starts a note; otherwise only a different key
  // restarts, so holding the same key after a one-shot stays in DONE.
  assign note_event   = !invalid_note && ((state == IDLE) || (note_addr != base));
  assign note_release = invalid_note && (state != IDLE);

endmodule

// File: rtl/sampler_note_player.sv
// rtl/sampler_note_player.sv - streams one PCM sample per audio tick from sample memory
//
// Purpose: latches the note start address from the keymapper and, on every
// sample_tick, reads the next word of the note region over a req/ack memory
// handshake, presenting it on sample_out for the codec serializer.
// Optional feature: `define SAMPLER_LOOP_EN to loop the note region while the
// key is held; the default build plays each note once and stops in DONE.
// Ports:
//   Clk, Reset    in   clock, asynchronous active-high reset
//   note_addr     in   start word address of selected note (level)
//   invalid_note  in   1 = no valid key pressed (level)
//   sample_tick   in   one-Clk pulse at audio sample rate
//   mem_req       out  read request, held until mem_ack
//   mem_addr      out  read address, stable while mem_req=1
//   mem_ack       in   read complete, mem_data valid this cycle
//   mem_data      in   read data
//   sample_out    out  current sample, held between updates
//   sample_valid  out  one-cycle pulse when sample_out updates
//   playing       out  1 while a note is active
//   overrun       out  one-cycle pulse when a tick is dropped
module sampler_note_player
  import sampler_pkg::*;
#(
  parameter int ADDR_W   = sampler_pkg::ADDR_W,
  parameter int DATA_W   = sampler_pkg::DATA_W,
  parameter int NOTE_LEN = sampler_pkg::NOTE_LEN
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] note_addr,
  input  logic              invalid_note,
  input  logic              sample_tick,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              playing,
  output logic              overrun
);

  localparam logic [OFFSET_W-1:0] LAST_OFFSET = OFFSET_W'(NOTE_LEN - 1);

  player_state_t       state;
  logic [ADDR_W-1:0]   base;
  logic [OFFSET_W-1:0] offset;
  logic                abort_pending;
  logic                note_event;
  logic                note_release;
  logic [ADDR_W-1:0]   cur_addr;

  // Wraps modulo 2^ADDR_W by construction of the sum width.
  assign cur_addr = base + ADDR_W'(offset);

  sampler_note_event_detect #(
    .ADDR_W (ADDR_W)
  ) u_event_detect (
    .state        (state),
    .note_addr    (note_addr),
    .invalid_note (invalid_note),
    .base         (base),
    .note_event   (note_event),
    .note_release (note_release)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= IDLE;
      base          <= '0;
      offset        <= '0;
      abort_pending <= 1'b0;
      sample_out    <= '0;
      sample_valid  <= 1'b0;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      playing       <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      overrun      <= 1'b0;

      case (state)
        IDLE: begin
          playing <= 1'b0;
          if (note_event) begin
            base    <= note_addr;
            offset  <= '0;
            playing <= 1'b1;
            state   <= WAIT_TICK;
          end
        end

        WAIT_TICK: begin
          if (note_release) begin
            abort_pending <= 1'b0;
            sample_out    <= '0;
            playing       <= 1'b0;
            state         <= IDLE;
          end else if (note_event || abort_pending) begin
            // A restart wins over a same-cycle tick; the tick becomes the
            // first fetch of the new note, addressed straight from note_addr.
            base          <= note_addr;
            offset        <= '0;
            abort_pending <= 1'b0;
            if (sample_tick) begin
              mem_addr <= note_addr;
              mem_req  <= 1'b1;
              state    <= FETCH;
            end
          end else if (sample_tick) begin
            mem_addr <= cur_addr;
            mem_req  <= 1'b1;
            state    <= FETCH;
          end
        end

        FETCH: begin
          // The request in flight cannot be cancelled, so ticks are dropped.
          if (sample_tick) begin
            overrun <= 1'b1;
          end
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (abort_pending || note_event || note_release) begin
              // Discard the read; WAIT_TICK applies the event from the
              // keymapper values seen on the following cycle.
              abort_pending <= 1'b1;
              state         <= WAIT_TICK;
            end else begin
              sample_out   <= mem_data;
              sample_valid <= 1'b1;
              if (offset == LAST_OFFSET) begin
`ifdef SAMPLER_LOOP_EN
                offset <= '0;
                state  <= WAIT_TICK;
`else
                playing <= 1'b0;
                state   <= DONE;
`endif
              end else begin
                offset <= offset + 16'd1;
                state  <= WAIT_TICK;
              end
            end
          end else if (note_event || note_release) begin
            abort_pending <= 1'b1;
          end
        end

        DONE: begin
          // The last sample is shown for one cycle, then output goes silent.
          sample_out <= '0;
          playing    <= 1'b0;
          if (note_release) begin
            state <= IDLE;
          end else if (note_event) begin
            base    <= note_addr;
            offset  <= '0;
            playing <= 1'b1;
            state   <= WAIT_TICK;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
